mmac_operand_loader: RTL and testbench
======================================

// Module: mmac_operand_loader
// PURPOSE
//  Producer side of the packed-matrix interface consumed by matrix_multiply_unit.
//  Accepts a byte-serial element stream (valid/ready): 16 elements of A, then 16 of B.
//  Assembles both into packed DATA_WIDTH words; presents them as a pair with a valid/ready handshake.
//  Sits between the host/DMA stream and the multiply/accumulate datapath.
// PARAMETERS
//  M_SIZE      4    matrix dimension (M_SIZE x M_SIZE); defaults to mmac_pkg::M_SIZE
//  VAR_WIDTH   8    element width in bits; defaults to mmac_pkg::VAR_WIDTH
//  DATA_WIDTH  M_SIZE*M_SIZE*VAR_WIDTH (128)  packed matrix width (derived, not overridden)
// PORTS
//  clock      in   1           clock, all logic on rising edge
//  reset      in   1           synchronous, active-low
//  in_valid   in   1           element beat valid
//  in_ready   out  1           loader can accept a beat
//  in_data    in   VAR_WIDTH   element value
//  in_last    in   1           marks the final (32nd) beat of an A+B frame
//  mat_valid  out  1           matrixA/matrixB hold a complete pair
//  mat_ready  in   1           consumer takes the pair
//  matrixA    out  DATA_WIDTH  packed A
//  matrixB    out  DATA_WIDTH  packed B
//  err_len    out  1           one-cycle pulse: frame length / in_last mismatch
// BEHAVIOUR
//  - Reset (reset==0 at clock edge): state=LOAD_A, beat_cnt=0, in_ready=0 that cycle then 1,
//    mat_valid=0, err_len=0, matrixA=matrixB=0. Reset mid-frame discards all partial data.
//  - Packing: element (r,c) at bits [(r*M_SIZE+c)*VAR_WIDTH +: VAR_WIDTH]; beats arrive row-major.
//  - Beat accepted when in_valid && in_ready. beat_cnt (4 bits) indexes the element within a matrix.
//  - FSM:
//    LOAD_A: in_ready=1; write A[beat_cnt]; at beat_cnt==15 -> LOAD_B, beat_cnt=0.
//    LOAD_B: in_ready=1; write B[beat_cnt]; at beat_cnt==15 -> HOLD.
//    HOLD:   in_ready=0, mat_valid=1; on mat_ready -> LOAD_A, beat_cnt=0.
//  - Latency: mat_valid rises the cycle after the 32nd accepted beat. No ready bypass:
//    in_ready returns the cycle after the mat_ready handshake. Minimum period: 33 cycles/pair.
//  - matrixA/matrixB only change on accepted beats; stable throughout HOLD.
//    Upstream registers retain the last pair after the handshake until overwritten.
//  - in_last on any beat other than the 32nd: err_len pulses next cycle.
//    Frame is aborted: -> LOAD_A, beat_cnt=0, no mat_valid.
//  - 32nd beat without in_last: err_len pulses next cycle; pair is still delivered (HOLD).
//  - in_valid while in HOLD: ignored (in_ready=0); no data loss upstream.
//  - mat_ready while mat_valid==0: no effect.
// CONFIGURATION
//  MMAC_LOADER_BCOL_EN defined: B beats arrive column-major.
//    Beat k is written to B element (r=k%M_SIZE, c=k/M_SIZE). A stays row-major.
//  Undefined: B is row-major like A. Output packing is identical in both builds.
// STRUCTURE
//  mmac_pkg: M_SIZE, VAR_WIDTH, DATA_WIDTH constants;
//    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} loader_state_e; typedef elem_t.
//  Sub-module mmac_elem_buf: one M_SIZE*M_SIZE element register file.
//    Ports: write-enable, linear index, col_major select; packed read-out.
//    Instantiated twice (A, B).
// TESTING
//  1. Reset, stream A=1..16, B=all 1, in_last on beat 32, mat_ready=1
//     -> mat_valid cycle 33; matrixA[7:0]=1, matrixA[127:120]=16, matrixB=all 8'h01.
//  2. Hold mat_ready=0 for 10 cycles after frame
//     -> mat_valid stays 1, in_ready=0, outputs unchanged; in_ready=1 cycle after handshake.
//  3. in_last on beat 20 -> err_len pulse one cycle later, no mat_valid;
//     the next full 32-beat frame delivers correctly.
//  4. 32 beats, in_last=0 throughout -> err_len pulse and mat_valid both assert the cycle after beat 32.
//  5. Assert reset at beat 10 of B, then a full frame -> only the new frame appears; no err_len.
//  6. MMAC_LOADER_BCOL_EN: B beats 0..15 -> matrixB element (r,c) == 4*c+r
//     (e.g. bits [15:8] = 4); A unaffected.

Source files
------------

// File: rtl/mmac_pkg.sv
// rtl/mmac_pkg.sv - shared constants and types for the packed-matrix operand loader
//
// Purpose : default matrix geometry, element type and the loader FSM state
//           encoding used by mmac_operand_loader and mmac_elem_buf.
// Contents: M_SIZE, VAR_WIDTH, N_ELEM, DATA_WIDTH constants;
//           elem_t element type; loader_state_e FSM states;
//           col_major_pos() helper mapping a column-major beat index to
//           its row-major packed position.

package mmac_pkg;

    localparam int M_SIZE     = 4;
    localparam int VAR_WIDTH  = 8;
    localparam int N_ELEM     = M_SIZE * M_SIZE;
    localparam int DATA_WIDTH = N_ELEM * VAR_WIDTH;

    typedef logic [VAR_WIDTH-1:0] elem_t;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } loader_state_e;

    // Beat k of a column-major stream is element (r = k % m, c = k / m),
    // which lives at packed position r*m + c.
    function automatic int unsigned col_major_pos(input int unsigned k, input int unsigned m);
        return (k % m) * m + (k / m);
    endfunction

endpackage

// File: rtl/mmac_elem_buf.sv
// rtl/mmac_elem_buf.sv - one M_SIZE x M_SIZE element register file with packed read-out
//
// Purpose : stores one matrix, one element per write, and presents it as a
//           single packed word (element (r,c) at bits
//           [(r*M_SIZE+c)*VAR_WIDTH +: VAR_WIDTH]).
// Ports   :
//   clock        in   1                 rising-edge clock
//   reset        in   1                 synchronous, active-low; clears all elements
//   wr_en_i      in   1                 write one element this cycle
//   wr_idx_i     in   IDX_W             linear beat index within the matrix
//   wr_data_i    in   VAR_WIDTH         element value
//   col_major_i  in   1                 1: wr_idx_i counts column-major; 0: row-major
//   data_o       out  N*VAR_WIDTH       packed matrix

module mmac_elem_buf #(
    parameter int M_SIZE    = mmac_pkg::M_SIZE,
    parameter int VAR_WIDTH = mmac_pkg::VAR_WIDTH,
    localparam int N        = M_SIZE * M_SIZE,
    localparam int IDX_W    = $clog2(N),
    localparam int DW       = N * VAR_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [VAR_WIDTH-1:0] wr_data_i,
    input  logic                 col_major_i,
    output logic [DW-1:0]        data_o
);

    import mmac_pkg::*;

    logic [DW-1:0]    data_q;
    logic [IDX_W-1:0] pos;

    // Storage is always row-major; only the incoming index is remapped.
    always_comb begin
        pos = wr_idx_i;
        if (col_major_i) begin
            pos = IDX_W'(col_major_pos(int'(wr_idx_i), M_SIZE));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= '0;
        end else if (wr_en_i) begin
            data_q[pos*VAR_WIDTH +: VAR_WIDTH] <= wr_data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/mmac_operand_loader.sv
// rtl/mmac_operand_loader.sv - byte-serial A+B element stream to packed matrix pair
//
// Purpose : accepts N_ELEM beats of A then N_ELEM beats of B (valid/ready),
//           packs each into a DATA_WIDTH word and holds the pair for the
//           multiply/accumulate consumer behind a valid/ready handshake.
//           Frames whose in_last marker is misplaced are aborted with an
//           err_len pulse; a final beat missing in_last still delivers the
//           pair but also pulses err_len.
// Build option: define MMAC_LOADER_BCOL_EN to accept B beats column-major
//           (A is always row-major; output packing is the same either way).
// Ports   :
//   clock      in   1           rising-edge clock
//   reset      in   1           synchronous, active-low
//   in_valid   in   1           element beat valid
//   in_ready   out  1           loader can accept a beat
//   in_data    in   VAR_WIDTH   element value
//   in_last    in   1           marks the final beat of an A+B frame
//   mat_valid  out  1           matrixA/matrixB hold a complete pair
//   mat_ready  in   1           consumer takes the pair
//   matrixA    out  DATA_WIDTH  packed A
//   matrixB    out  DATA_WIDTH  packed B
//   err_len    out  1           one-cycle pulse on frame length / in_last mismatch

module mmac_operand_loader #(
    parameter int M_SIZE     = mmac_pkg::M_SIZE,
    parameter int VAR_WIDTH  = mmac_pkg::VAR_WIDTH,
    localparam int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VAR_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  mat_valid,
    input  logic                  mat_ready,
    output logic [DATA_WIDTH-1:0] matrixA,
    output logic [DATA_WIDTH-1:0] matrixB,
    output logic                  err_len
);

    import mmac_pkg::*;

    localparam int               N_EL     = M_SIZE * M_SIZE;
    localparam int               IDX_W    = $clog2(N_EL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EL - 1);

`ifdef MMAC_LOADER_BCOL_EN
    localparam logic B_COL_MAJOR = 1'b1;
`else
    localparam logic B_COL_MAJOR = 1'b0;
`endif

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             err_q, err_d;
    logic             wr_a, wr_b;
    logic             beat;

    assign beat = in_valid && in_ready_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= LOAD_A;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_a    = 1'b0;
        wr_b    = 1'b0;

        case (state_q)
            LOAD_A: begin
                if (beat) begin
                    wr_a = 1'b1;
                    if (in_last) begin
                        // in_last can never be legal inside A: abort the frame.
                        err_d   = 1'b1;
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    wr_b = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        // Missing in_last is flagged but the pair is still usable.
                        err_d   = !in_last;
                        state_d = HOLD;
                    end else if (in_last) begin
                        err_d   = 1'b1;
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (mat_ready) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered ready: no combinational path from mat_ready to in_ready,
    // so a freed loader accepts again only the cycle after the handshake.
    assign in_ready_d = (state_d != HOLD);

    assign in_ready  = in_ready_q;
    assign mat_valid = (state_q == HOLD);
    assign err_len   = err_q;

    mmac_elem_buf #(
        .M_SIZE    (M_SIZE),
        .VAR_WIDTH (VAR_WIDTH)
    ) u_buf_a (
        .clock       (clock),
        .reset       (reset),
        .wr_en_i     (wr_a),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (in_data),
        .col_major_i (1'b0),
        .data_o      (matrixA)
    );

    mmac_elem_buf #(
        .M_SIZE    (M_SIZE),
        .VAR_WIDTH (VAR_WIDTH)
    ) u_buf_b (
        .clock       (clock),
        .reset       (reset),
        .wr_en_i     (wr_b),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (in_data),
        .col_major_i (B_COL_MAJOR),
        .data_o      (matrixB)
    );

endmodule

// File: tb/tb_mmac_operand_loader.sv
// tb/tb_mmac_operand_loader.sv - scoreboard bench for mmac_operand_loader

module tb_mmac_operand_loader;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         mat_valid;
    logic         mat_ready;
    logic [127:0] matrixA;
    logic [127:0] matrixB;
    logic         err_len;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = -1;

    logic [7:0] beats [32];

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
    } pair_t;

    pair_t sb_q [$];
    pair_t mon_p;
    pair_t hold_p;
    bit    mv_prev = 1'b0;

`ifdef MMAC_LOADER_BCOL_EN
    localparam bit BCOL = 1'b1;
`else
    localparam bit BCOL = 1'b0;
`endif

    mmac_operand_loader dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .matrixA   (matrixA),
        .matrixB   (matrixB),
        .err_len   (err_len)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic pair_t model();
        pair_t p;
        int    pos;
        p.a = '0;
        p.b = '0;
        for (int k = 0; k < 16; k++) begin
            p.a[k*8 +: 8] = beats[k];
            pos = BCOL ? ((k % 4) * 4 + k / 4) : k;
            p.b[pos*8 +: 8] = beats[16+k];
        end
        return p;
    endfunction

    // Scoreboard consumer: each new pair presented is compared with the oldest expectation.
    always @(negedge clock) begin
        if (mat_valid && !mv_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pair", 128'(1), 128'(0));
            end else begin
                mon_p = sb_q.pop_front();
                check("pair_a", matrixA, mon_p.a);
                check("pair_b", matrixB, mon_p.b);
                check("pair_latency", 128'(cyc), 128'(last_acc_cyc));
            end
        end
        mv_prev = mat_valid;
    end

    task automatic send_beat(input logic [7:0] d, input bit l);
        int guard = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 128'(0), 128'(1));
        last_acc_cyc = cyc + 1;
    endtask

    task automatic send_frame(input int n, input int last_at, input bit deliver, input bit exp_err);
        if (deliver) sb_q.push_back(model());
        for (int k = 0; k < n; k++) send_beat(beats[k], k == last_at);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("err_len_pulse", 128'(err_len), 128'(exp_err));
        check("mat_valid_after_frame", 128'(mat_valid), 128'(deliver));
        if (!deliver) check("in_ready_after_abort", 128'(in_ready), 128'(1));
        @(negedge clock);
        check("err_len_one_cycle", 128'(err_len), 128'(0));
    endtask

    task automatic rand_beats();
        for (int k = 0; k < 32; k++) beats[k] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        mat_ready = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_mat_valid", 128'(mat_valid), 128'(0));
        check("rst_err_len", 128'(err_len), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_matrixA", matrixA, 128'(0));
        check("rst_matrixB", matrixB, 128'(0));
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 128'(in_ready), 128'(1));

        // 1: A = 1..16, B = all ones, consumer always ready
        mat_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            beats[k]    = 8'(k + 1);
            beats[16+k] = 8'h01;
        end
        send_frame(32, 31, 1'b1, 1'b0);
        check("t1_a_low", 128'(matrixA[7:0]), 128'(1));
        check("t1_a_high", 128'(matrixA[127:120]), 128'(16));
        check("t1_b_ones", matrixB, {16{8'h01}});
        check("t1_in_ready_back", 128'(in_ready), 128'(1));

        // 2: consumer stalls 10 cycles; upstream keeps offering a beat meanwhile
        mat_ready = 1'b0;
        rand_beats();
        hold_p = model();
        send_frame(32, 31, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t2_hold_valid", 128'(mat_valid), 128'(1));
            check("t2_hold_ready", 128'(in_ready), 128'(0));
            check("t2_hold_a", matrixA, hold_p.a);
            check("t2_hold_b", matrixB, hold_p.b);
        end
        in_valid  = 1'b0;
        mat_ready = 1'b1;
        @(negedge clock);
        check("t2_ready_after_hs", 128'(in_ready), 128'(1));
        check("t2_valid_after_hs", 128'(mat_valid), 128'(0));
        check("t2_a_retained", matrixA, hold_p.a);

        // 3: in_last on beat 20 aborts, next frame is clean
        rand_beats();
        send_frame(20, 19, 1'b0, 1'b1);
        rand_beats();
        send_frame(32, 31, 1'b1, 1'b0);

        // 4: no in_last at all -> error pulse, pair still delivered
        rand_beats();
        send_frame(32, -1, 1'b1, 1'b1);

        // 5: reset during B beat 10, then a fresh frame
        rand_beats();
        for (int k = 0; k < 26; k++) send_beat(beats[k], 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("t5_rst_a", matrixA, 128'(0));
        check("t5_rst_b", matrixB, 128'(0));
        check("t5_rst_err", 128'(err_len), 128'(0));
        check("t5_rst_valid", 128'(mat_valid), 128'(0));
        @(negedge clock);
        check("t5_err_quiet", 128'(err_len), 128'(0));
        rand_beats();
        send_frame(32, 31, 1'b1, 1'b0);

        // 6: B = 0..15 in stream order
        rand_beats();
        for (int k = 0; k < 16; k++) beats[16+k] = 8'(k);
        send_frame(32, 31, 1'b1, 1'b0);
        check("t6_b_elem01", 128'(matrixB[15:8]), BCOL ? 128'(4) : 128'(1));
        check("t6_b_elem00", 128'(matrixB[7:0]), 128'(0));
        check("t6_b_elem10", 128'(matrixB[39:32]), BCOL ? 128'(1) : 128'(4));

        repeat (3) @(negedge clock);
        check("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
